// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - Hack instruction field positions, comp codes and sequencer states
package hack_pkg;

  localparam int OP_BIT    = 15;
  localparam int A_SEL_BIT = 12;
  localparam int COMP_HI   = 11;
  localparam int COMP_LO   = 6;
  localparam int DEST_HI   = 5;
  localparam int DEST_LO   = 3;
  localparam int JUMP_HI   = 2;
  localparam int JUMP_LO   = 0;

  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;

  localparam logic [5:0] COMP_ZERO     = 6'b101010;
  localparam logic [5:0] COMP_ONE      = 6'b111111;
  localparam logic [5:0] COMP_D        = 6'b001100;
  localparam logic [5:0] COMP_A        = 6'b110000;
  localparam logic [5:0] COMP_D_PLUS_A = 6'b000010;
  localparam logic [5:0] COMP_D_OR_A   = 6'b010101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } seq_state_t;

  // Only 111xxxxx... is a well-formed C-instruction; bits 14:13 must be set.
  function automatic logic c_bits_legal(input logic [15:0] ins);
    return ins[14] & ins[13];
  endfunction

endpackage

// File: rtl/hack_jump_eval.sv
// rtl/hack_jump_eval.sv - Hack jump condition from j[2:0] and the ALU flags
module hack_jump_eval (
  input  logic [2:0] i_j,
  input  logic       i_zr,
  input  logic       i_ng,
  output logic       o_take
);

  assign o_take = (i_j[2] & i_ng) | (i_j[1] & i_zr) | (i_j[0] & ~i_ng & ~i_zr);

endmodule

// File: rtl/hack_alu_sequencer.sv
// rtl/hack_alu_sequencer.sv - Hack A/D register owner and ALU sequencer (IDLE/EXEC/WB)
// Optional macro ALU_SEQ_ILLEGAL_CHK_EN: reject C-instructions with IR[14:13]!=2'b11 via err.
module hack_alu_sequencer
  import hack_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  input  logic [WIDTH-1:0] m_in,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] d_reg,
  output logic [WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0] m_out,
  output logic             m_we,
  output logic             jump,
  output logic [WIDTH-1:0] jump_addr,
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
  output logic             err,
`endif
  output logic             done
);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [15:0]      r_ir;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_res;
  logic             r_zr;
  logic             r_ng;
  logic [WIDTH-1:0] r_m_addr;
  logic [WIDTH-1:0] r_m_out;
  logic [WIDTH-1:0] r_jump_addr;

  logic w_in_legal;
  logic w_ir_legal;
  logic w_ir_is_c;
  logic w_take;
  logic w_wb_c;

`ifdef ALU_SEQ_ILLEGAL_CHK_EN
  assign w_in_legal = ~instr[OP_BIT] | c_bits_legal(instr);
  assign w_ir_legal = ~r_ir[OP_BIT] | c_bits_legal(r_ir);
  assign err        = (r_state == WB) & ~w_ir_legal;
`else
  assign w_in_legal = 1'b1;
  assign w_ir_legal = 1'b1;
`endif

  assign w_ir_is_c = r_ir[OP_BIT];
  assign w_wb_c    = (r_state == WB) & w_ir_is_c & w_ir_legal;

  hack_jump_eval u_jump_eval (
    .i_j    (r_ir[JUMP_HI:JUMP_LO]),
    .i_zr   (r_zr),
    .i_ng   (r_ng),
    .o_take (w_take)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (instr_valid) begin
          // A-instructions and rejected C-instructions skip the ALU cycle.
          w_next = (instr[OP_BIT] && w_in_legal) ? EXEC : WB;
        end
      end
      EXEC:    w_next = WB;
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (r_state == IDLE);
    alu_x       = '0;
    alu_y       = '0;
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b0;
    if (r_state == EXEC) begin
      alu_x = r_d;
      alu_y = r_ir[A_SEL_BIT] ? m_in : r_a;
      {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = r_ir[COMP_HI:COMP_LO];
    end
  end

  // During WB the addresses reflect A as it was before this instruction's update.
  assign done      = (r_state == WB);
  assign m_we      = w_wb_c & r_ir[DEST_M];
  assign jump      = w_wb_c & w_take;
  assign m_addr    = (r_state == WB) ? r_a : r_m_addr;
  assign jump_addr = (r_state == WB) ? r_a : r_jump_addr;
  assign m_out     = w_wb_c ? r_res : r_m_out;
  assign a_reg     = r_a;
  assign d_reg     = r_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ir        <= '0;
      r_a         <= '0;
      r_d         <= '0;
      r_res       <= '0;
      r_zr        <= 1'b0;
      r_ng        <= 1'b0;
      r_m_addr    <= '0;
      r_m_out     <= '0;
      r_jump_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && instr_valid) begin
        r_ir <= instr;
      end
      if (r_state == EXEC) begin
        r_res <= alu_out;
        r_zr  <= alu_zr;
        r_ng  <= alu_ng;
      end
      if (r_state == WB) begin
        r_m_addr    <= r_a;
        r_jump_addr <= r_a;
        if (!w_ir_is_c) begin
          r_a <= {1'b0, r_ir[14:0]};
        end else if (w_ir_legal) begin
          if (r_ir[DEST_A]) r_a <= r_res;
          if (r_ir[DEST_D]) r_d <= r_res;
          r_m_out <= r_res;
        end
      end
    end
  end

endmodule
